// File: rtl/craps_game_ctrl_if.sv
// Signal bundle between the craps controller, the dice/adder datapath and the score/display logic.
// The master side drives the button, sum and new-game inputs; the controller is the slave.
interface craps_game_ctrl_if #(
   parameter int SUM_W  = 4,
   parameter int CNT_W  = 8,
   parameter int RCNT_W = 8
);
   logic              rb;
   logic              sum_valid;
   logic [SUM_W-1:0]  sum;
   logic              new_game;
   logic              roll;
   logic              win;
   logic              lose;
   logic [SUM_W-1:0]  point;
   logic              point_valid;
   logic [RCNT_W-1:0] roll_cnt;
   logic [CNT_W-1:0]  win_cnt;
   logic [CNT_W-1:0]  lose_cnt;
   logic              err;

   modport master (
      output rb, sum_valid, sum, new_game,
      input  roll, win, lose, point, point_valid, roll_cnt, win_cnt, lose_cnt, err
   );

   modport slave (
      input  rb, sum_valid, sum, new_game,
      output roll, win, lose, point, point_valid, roll_cnt, win_cnt, lose_cnt, err
   );
endinterface

// File: rtl/craps_game_ctrl.sv
// Craps game controller: come-out roll, point tracking, point rolls, win/lose and tallies.
// Button edge and dice result are registered first, so the FSM acts one edge after sampling.
module craps_game_ctrl #(
   parameter int SUM_W     = 4,
   parameter int MAX_ROLLS = 0,
   parameter int CNT_W     = 8,
   parameter int RCNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   craps_game_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_CO_ROLL, S_PT_WAIT, S_PT_ROLL, S_WIN, S_LOSE
   } state_t;

   localparam logic [RCNT_W-1:0] MAX_R = RCNT_W'(MAX_ROLLS);

   state_t            state_q, state_d;
   logic              rb_q, rb_d, rise_q, rise_d, sv_q, sv_d;
   logic [SUM_W-1:0]  sum_q, sum_d, point_q, point_d;
   logic              roll_q, roll_d, win_q, win_d, lose_q, lose_d;
   logic              pv_q, pv_d, err_q, err_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d, rcnt_inc;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d, wcnt_inc, lcnt_q, lcnt_d, lcnt_inc;
   logic              legal;

   always_comb begin
      rb_d     = bus.rb;
      rise_d   = bus.rb & ~rb_q;
      sv_d     = bus.sum_valid;
      sum_d    = bus.sum;
      state_d  = state_q;
      point_d  = point_q;
      rcnt_d   = rcnt_q;
      wcnt_d   = wcnt_q;
      lcnt_d   = lcnt_q;
      roll_d   = 1'b0;
      err_d    = 1'b0;
      legal    = (sum_q >= SUM_W'(2)) && (sum_q <= SUM_W'(12));
      rcnt_inc = (&rcnt_q) ? rcnt_q : rcnt_q + RCNT_W'(1);
      wcnt_inc = (&wcnt_q) ? wcnt_q : wcnt_q + CNT_W'(1);
      lcnt_inc = (&lcnt_q) ? lcnt_q : lcnt_q + CNT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (rise_q) begin
               roll_d  = 1'b1;
               state_d = S_CO_ROLL;
            end
         end
         S_CO_ROLL: begin
            if (sv_q) begin
               if (!legal) begin
                  err_d = 1'b1;
               end else if (sum_q == SUM_W'(7) || sum_q == SUM_W'(11)) begin
                  state_d = S_WIN;
                  wcnt_d  = wcnt_inc;
               end else if (sum_q == SUM_W'(2) || sum_q == SUM_W'(3) || sum_q == SUM_W'(12)) begin
                  state_d = S_LOSE;
                  lcnt_d  = lcnt_inc;
               end else begin
                  point_d = sum_q;
                  rcnt_d  = '0;
                  state_d = S_PT_WAIT;
               end
            end
         end
         S_PT_WAIT: begin
            if (rise_q) begin
               roll_d  = 1'b1;
               state_d = S_PT_ROLL;
            end
         end
         S_PT_ROLL: begin
            if (sv_q) begin
               if (!legal) begin
                  err_d = 1'b1;
               end else begin
                  rcnt_d = rcnt_inc;
                  // Matching the point beats a seven, which beats the roll limit.
                  if (sum_q == point_q) begin
                     state_d = S_WIN;
                     wcnt_d  = wcnt_inc;
                     point_d = '0;
                  end else if (sum_q == SUM_W'(7) ||
                               (MAX_ROLLS != 0 && rcnt_inc == MAX_R)) begin
                     state_d = S_LOSE;
                     lcnt_d  = lcnt_inc;
                     point_d = '0;
                  end else begin
                     state_d = S_PT_WAIT;
                  end
               end
            end
         end
         S_WIN, S_LOSE: begin
            if (bus.new_game) begin
               state_d = S_IDLE;
               point_d = '0;
               rcnt_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      win_d  = (state_d == S_WIN);
      lose_d = (state_d == S_LOSE);
      pv_d   = (state_d == S_PT_WAIT) || (state_d == S_PT_ROLL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rb_q    <= 1'b0;
         rise_q  <= 1'b0;
         sv_q    <= 1'b0;
         sum_q   <= '0;
         point_q <= '0;
         rcnt_q  <= '0;
         wcnt_q  <= '0;
         lcnt_q  <= '0;
         roll_q  <= 1'b0;
         err_q   <= 1'b0;
         win_q   <= 1'b0;
         lose_q  <= 1'b0;
         pv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rb_q    <= rb_d;
         rise_q  <= rise_d;
         sv_q    <= sv_d;
         sum_q   <= sum_d;
         point_q <= point_d;
         rcnt_q  <= rcnt_d;
         wcnt_q  <= wcnt_d;
         lcnt_q  <= lcnt_d;
         roll_q  <= roll_d;
         err_q   <= err_d;
         win_q   <= win_d;
         lose_q  <= lose_d;
         pv_q    <= pv_d;
      end
   end

   assign bus.roll        = roll_q;
   assign bus.win         = win_q;
   assign bus.lose        = lose_q;
   assign bus.point       = point_q;
   assign bus.point_valid = pv_q;
   assign bus.roll_cnt    = rcnt_q;
   assign bus.win_cnt     = wcnt_q;
   assign bus.lose_cnt    = lcnt_q;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_craps_game_ctrl.sv
// Randomised and directed bench for craps_game_ctrl with a game-rule reference model.
// The DUT is built with a three-roll point limit.
module tb_craps_game_ctrl;
   localparam int MAXR = 3;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   craps_game_ctrl_if #(.SUM_W(4), .CNT_W(8), .RCNT_W(8)) bus ();

   craps_game_ctrl #(.SUM_W(4), .MAX_ROLLS(MAXR), .CNT_W(8), .RCNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: game phase, point, point-roll count and tallies.
   localparam int PH_IDLE = 0, PH_CO = 1, PH_PTW = 2, PH_PTR = 3, PH_WIN = 4, PH_LOSE = 5;
   int m_ph, m_pt, m_rc, m_w, m_l;

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic void model_reset();
      m_ph = PH_IDLE; m_pt = 0; m_rc = 0; m_w = 0; m_l = 0;
   endfunction

   function automatic void model_end(input bit won);
      m_ph = won ? PH_WIN : PH_LOSE;
      m_pt = 0;
      if (won) m_w = sat(m_w + 1);
      else     m_l = sat(m_l + 1);
   endfunction

   function automatic bit model_rb();
      if (m_ph == PH_IDLE) begin m_ph = PH_CO;  return 1'b1; end
      if (m_ph == PH_PTW)  begin m_ph = PH_PTR; return 1'b1; end
      return 1'b0;
   endfunction

   function automatic bit model_sum(input int s);
      if (m_ph != PH_CO && m_ph != PH_PTR) return 1'b0;
      if (s < 2 || s > 12) return 1'b1;
      if (m_ph == PH_CO) begin
         if (s == 7 || s == 11) model_end(1'b1);
         else if (s == 2 || s == 3 || s == 12) model_end(1'b0);
         else begin m_pt = s; m_rc = 0; m_ph = PH_PTW; end
      end else begin
         m_rc = sat(m_rc + 1);
         if (s == m_pt) model_end(1'b1);
         else if (s == 7 || m_rc == MAXR) model_end(1'b0);
         else m_ph = PH_PTW;
      end
      return 1'b0;
   endfunction

   function automatic void model_new();
      if (m_ph == PH_WIN || m_ph == PH_LOSE) begin
         m_ph = PH_IDLE; m_pt = 0; m_rc = 0;
      end
   endfunction

   function automatic logic [30:0] exp_vec();
      return {m_ph == PH_WIN, m_ph == PH_LOSE, (m_ph == PH_PTW || m_ph == PH_PTR),
              4'(m_pt), 8'(m_rc), 8'(m_w), 8'(m_l)};
   endfunction

   function automatic logic [30:0] obs_vec();
      return {bus.win, bus.lose, bus.point_valid, bus.point, bus.roll_cnt, bus.win_cnt, bus.lose_cnt};
   endfunction

   // Drivers: all start and end just after a falling edge.
   task automatic drive_rb(output int pulses, output int first, output bit exp_roll);
      pulses = 0; first = 0;
      exp_roll = model_rb();
      bus.rb = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) bus.rb = 1'b0;
         if (bus.roll) begin pulses++; if (first == 0) first = i; end
      end
      $display("rb press: expect_roll=%0b roll_pulses=%0d at=%0d", exp_roll, pulses, first);
   endtask

   task automatic drive_sum(input int s, output int pulses, output int first, output bit exp_err);
      pulses = 0; first = 0;
      exp_err = model_sum(s);
      bus.sum_valid = 1'b1;
      bus.sum = 4'(s);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         if (i == 1) begin bus.sum_valid = 1'b0; bus.sum = 4'($urandom); end
         if (bus.err) begin pulses++; if (first == 0) first = i; end
      end
      $display("sum=%0d: expect_err=%0b err_pulses=%0d win=%0b lose=%0b point=%0d rc=%0d",
               s, exp_err, pulses, bus.win, bus.lose, bus.point, bus.roll_cnt);
   endtask

   task automatic drive_new();
      model_new();
      bus.new_game = 1'b1;
      @(negedge clk);
      bus.new_game = 1'b0;
      $display("new_game: win=%0b lose=%0b", bus.win, bus.lose);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.rb = 1'b0; bus.sum_valid = 1'b0; bus.sum = '0; bus.new_game = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      total++;
      if ({bus.roll, bus.err, obs_vec()} !== 33'd0) begin
         bad++; $display("FAIL reset_state got=%h want=0", {bus.roll, bus.err, obs_vec()});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_comeout_win();
      int p, f, ep, ef; bit er, ee;
      drive_rb(p, f, er);
      total++;
      if (p !== 1 || f !== 2) begin bad++; $display("FAIL t1_roll pulses=%0d at=%0d want 1 at 2", p, f); end
      drive_sum(7, ep, ef, ee);
      total++;
      if (bus.win !== 1'b1 || bus.win_cnt !== 8'd1 || bus.point_valid !== 1'b0 || bus.lose !== 1'b0) begin
         bad++; $display("FAIL t1_win win=%0b win_cnt=%0d pv=%0b want 1 1 0", bus.win, bus.win_cnt, bus.point_valid);
      end
   endtask

   task automatic test_comeout_lose_hold();
      int p, f, ep, ef; bit er, ee;
      drive_new(); drive_rb(p, f, er); drive_sum(3, ep, ef, ee);
      total++;
      if (bus.lose !== 1'b1 || bus.lose_cnt !== 8'd1 || bus.win !== 1'b0) begin
         bad++; $display("FAIL t2_lose lose=%0b lose_cnt=%0d want 1 1", bus.lose, bus.lose_cnt);
      end
      p = 0;
      bus.rb = 1'b1;
      repeat (6) begin @(negedge clk); if (bus.roll) p++; end
      bus.rb = 1'b0;
      @(negedge clk);
      total++;
      if (p !== 0 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL t2_hold_rb pulses=%0d got=%h want 0 and %h", p, obs_vec(), exp_vec());
      end
   endtask

   task automatic test_point_win();
      int p, f, ep, ef; bit er, ee; int w0;
      drive_new();
      w0 = m_w;
      drive_rb(p, f, er); drive_sum(6, ep, ef, ee);
      total++;
      if (bus.point !== 4'd6 || bus.point_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL t3_point point=%0d pv=%0b want 6 1", bus.point, bus.point_valid);
      end
      drive_rb(p, f, er);
      total++;
      if (p !== 1 || f !== 2) begin bad++; $display("FAIL t3_pt_roll pulses=%0d at=%0d want 1 at 2", p, f); end
      drive_sum(8, ep, ef, ee); drive_rb(p, f, er); drive_sum(6, ep, ef, ee);
      total++;
      if (bus.win !== 1'b1 || bus.roll_cnt !== 8'd2 || bus.win_cnt !== 8'(w0 + 1) || bus.point !== 4'd0) begin
         bad++; $display("FAIL t3_win win=%0b rc=%0d wc=%0d point=%0d want 1 2 %0d 0",
                         bus.win, bus.roll_cnt, bus.win_cnt, bus.point, w0 + 1);
      end
   endtask

   task automatic test_seven_out_and_err();
      int p, f, ep, ef; bit er, ee;
      drive_new(); drive_rb(p, f, er); drive_sum(9, ep, ef, ee);
      drive_rb(p, f, er); drive_sum(7, ep, ef, ee);
      total++;
      if (bus.lose !== 1'b1 || bus.point_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL t4_seven_out got=%h want=%h", obs_vec(), exp_vec());
      end
      drive_new(); drive_rb(p, f, er); drive_sum(13, ep, ef, ee);
      total++;
      if (ep !== 1 || ef !== 2 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL t4_err pulses=%0d at=%0d got=%h want 1 at 2 %h", ep, ef, obs_vec(), exp_vec());
      end
      drive_sum(11, ep, ef, ee);
      total++;
      if (bus.win !== 1'b1 || ep !== 0) begin
         bad++; $display("FAIL t4_after_err win=%0b err=%0d want 1 0", bus.win, ep);
      end
   endtask

   task automatic test_roll_limit();
      int p, f, ep, ef; bit er, ee;
      drive_new(); drive_rb(p, f, er); drive_sum(5, ep, ef, ee);
      drive_rb(p, f, er); drive_sum(8, ep, ef, ee);
      drive_rb(p, f, er); drive_sum(4, ep, ef, ee);
      total++;
      if (bus.point_valid !== 1'b1 || bus.roll_cnt !== 8'd2) begin
         bad++; $display("FAIL t5_mid pv=%0b rc=%0d want 1 2", bus.point_valid, bus.roll_cnt);
      end
      drive_rb(p, f, er); drive_sum(10, ep, ef, ee);
      total++;
      if (bus.lose !== 1'b1 || bus.roll_cnt !== 8'd3 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL t5_limit lose=%0b rc=%0d want 1 3", bus.lose, bus.roll_cnt);
      end
   endtask

   task automatic test_random();
      int p, f, ep, ef, act, s; bit er, ee;
      for (int n = 0; n < 300; n++) begin
         act = int'($urandom_range(0, 9));
         if (act < 4) begin
            drive_rb(p, f, er);
            total++;
            if (er ? (p !== 1 || f !== 2) : (p !== 0)) begin
               bad++; $display("FAIL rand_roll step=%0d pulses=%0d at=%0d want_roll=%0b", n, p, f, er);
            end
         end else if (act < 9) begin
            s = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(2, 12));
            drive_sum(s, ep, ef, ee);
            total++;
            if (ee ? (ep !== 1 || ef !== 2) : (ep !== 0)) begin
               bad++; $display("FAIL rand_err step=%0d sum=%0d pulses=%0d at=%0d want_err=%0b", n, s, ep, ef, ee);
            end
         end else begin
            drive_new();
         end
         total++;
         if (obs_vec() !== exp_vec() || (bus.win && bus.lose)) begin
            bad++; $display("FAIL rand_state step=%0d got=%h want=%h", n, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid_game();
      int p, f, ep, ef; bit er, ee;
      rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
      model_reset();
      drive_rb(p, f, er); drive_sum(6, ep, ef, ee); drive_rb(p, f, er);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({bus.roll, bus.err, obs_vec()} !== 33'd0) begin
         bad++; $display("FAIL t6_reset_pt_roll got=%h want=0", {bus.roll, bus.err, obs_vec()});
      end
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_saturation();
      int p, f, ep, ef; bit er, ee;
      for (int g = 0; g < 257; g++) begin
         drive_new(); drive_rb(p, f, er); drive_sum(7, ep, ef, ee);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL sat_game g=%0d got=%h want=%h", g, obs_vec(), exp_vec());
         end
      end
      total++;
      if (bus.win_cnt !== 8'hFF) begin
         bad++; $display("FAIL sat_final win_cnt=%0d want 255", bus.win_cnt);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_comeout_win();
      test_comeout_lose_hold();
      test_point_win();
      test_seven_out_and_err();
      test_roll_limit();
      test_random();
      test_reset_mid_game();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
